ext_mem_arbiter: RTL
====================

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, external memory address width (log2 of ext mem height).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, external memory word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of the bandwidth counters.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port arst_in  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports r0_req  in  1, r0_addr  in  ADDR_WIDTH, r0_gnt  out  1, r0_rvalid  out  1, r0_rdata  out  DATA_WIDTH  read client 0 (feature-map fetch).
REQ-007 SHALL have ports r1_req  in  1, r1_addr  in  ADDR_WIDTH, r1_gnt  out  1, r1_rvalid  out  1, r1_rdata  out  DATA_WIDTH  read client 1 (kernel fetch).
REQ-008 SHALL have ports w_req  in  1, w_addr  in  ADDR_WIDTH, w_data  in  DATA_WIDTH, w_gnt  out  1  write client (output writeback).
REQ-009 SHALL have ports ext_mem_read_addr  out  ADDR_WIDTH, ext_mem_read_en  out  1, ext_mem_qout  in  DATA_WIDTH  memory read port.
REQ-010 SHALL have ports ext_mem_write_addr  out  ADDR_WIDTH, ext_mem_din  out  DATA_WIDTH, ext_mem_write_en  out  1  memory write port.
REQ-011 SHALL have ports clear_counts  in  1, rd_count  out  CNT_WIDTH, wr_count  out  CNT_WIDTH  bandwidth accounting.

Function
REQ-012 SHALL treat the memory as pseudo-2-port: at most one read and one write issued per cycle; qout valid exactly 1 cycle after read_en.
REQ-013 SHALL compute grants combinationally from current req and state; a request is accepted in the cycle req and gnt are both high; clients hold req/addr/data stable until gnt.
REQ-014 SHALL grant w_req whenever asserted (write always wins its own port); ext_mem_write_en = w_gnt, write_addr = w_addr, din = w_data.
REQ-015 SHALL arbitrate reads round-robin via register last_rd (0/1): single requester granted directly; both requesting -> client != last_rd granted.
REQ-016 SHALL update last_rd to the granted client index on every issued read; unchanged when no read issued.
REQ-017 SHALL drive ext_mem_read_en = r0_gnt | r1_gnt, read_addr = granted client address; read_addr = 0 when idle.
REQ-018 SHALL, on read/write hazard (candidate read address == w_addr with w_req high), suppress the read that cycle (no gnt to that client, last_rd unchanged); if the other read client requests a non-conflicting address it SHALL be granted instead.
REQ-019 SHALL register a response tag (valid bit + client index) on each issued read; next cycle assert rvalid of the tagged client for exactly one cycle with rdata = ext_mem_qout.
REQ-020 SHALL drive r0_rdata and r1_rdata to ext_mem_qout continuously; only rvalid qualifies.
REQ-021 SHALL support back-to-back reads every cycle, sustaining one read plus one write per cycle.
REQ-022 SHALL increment rd_count per issued read and wr_count per issued write, saturating at all-ones.
REQ-023 SHALL zero both counters on clear_counts; clear takes priority over same-cycle increment.

Reset
REQ-024 SHALL, while arst_in high, force last_rd = 1 (client 0 wins first tie), tag valid = 0, rd_count = wr_count = 0.
REQ-025 SHALL hold all gnt, rvalid and memory enables low during reset regardless of req inputs; addresses/din outputs 0.
REQ-026 SHALL discard a read in flight when reset asserts mid-operation: no rvalid after reset release.

Verification
REQ-027 Reset release, r0_req=1 addr 0x00010 and r1_req=1 addr 0x00020 held -> grants alternate r0,r1,r0,...; rvalid follows each grant by 1 cycle with correct client.
REQ-028 w_req addr 0x00055 and r0_req addr 0x00055 same cycle -> w_gnt=1, r0_gnt=0; next cycle r0 granted, r0_rdata equals written data.
REQ-029 Hazard on r0 (addr == w_addr) while r1 requests 0x00100 -> r1_gnt=1 same cycle, last_rd=1.
REQ-030 Preload CNT_WIDTH=4, 20 reads + 3 writes -> rd_count=15 (saturated), wr_count=3; clear_counts with simultaneous read -> both 0.
REQ-031 Assert arst_in the cycle after a read issue -> no rvalid ever appears for it; after release first tie goes to r0.

Source files
------------

// File: rtl/ext_mem_arbiter_if.sv
// Client and memory-side signals of the external memory arbiter.
// The slave modport is the arbiter; the master modport is the clients plus the memory.
interface ext_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  r0_req;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic                  r0_gnt;
  logic                  r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_req;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic                  r1_gnt;
  logic                  r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_rdata;

  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_gnt;

  logic [ADDR_WIDTH-1:0] ext_mem_read_addr;
  logic                  ext_mem_read_en;
  logic [DATA_WIDTH-1:0] ext_mem_qout;
  logic [ADDR_WIDTH-1:0] ext_mem_write_addr;
  logic [DATA_WIDTH-1:0] ext_mem_din;
  logic                  ext_mem_write_en;

  logic                  clear_counts;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic [CNT_WIDTH-1:0]  wr_count;

  modport slave (
    input  r0_req, r0_addr, r1_req, r1_addr, w_req, w_addr, w_data,
    input  ext_mem_qout, clear_counts,
    output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata, w_gnt,
    output ext_mem_read_addr, ext_mem_read_en,
    output ext_mem_write_addr, ext_mem_din, ext_mem_write_en,
    output rd_count, wr_count
  );

  modport master (
    output r0_req, r0_addr, r1_req, r1_addr, w_req, w_addr, w_data,
    output ext_mem_qout, clear_counts,
    input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata, w_gnt,
    input  ext_mem_read_addr, ext_mem_read_en,
    input  ext_mem_write_addr, ext_mem_din, ext_mem_write_en,
    input  rd_count, wr_count
  );
endinterface

// File: rtl/ext_mem_arbiter.sv
// Arbiter for a pseudo-2-port external memory: two round-robin read clients,
// one always-granted write client, and saturating bandwidth counters.
module ext_mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             arst_in,
  ext_mem_arbiter_if.slave bus
);

  logic                 gnt0;
  logic                 gnt1;
  logic                 gnt_w;
  logic                 ok0;
  logic                 ok1;
  logic                 rd_issue;
  logic                 last_rd;
  logic                 tag_vld_p1;
  logic                 tag_client_p1;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CNT_WIDTH-1:0] wr_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    gnt_w = 1'b0;
    ok0   = 1'b0;
    ok1   = 1'b0;
    if (!arst_in) begin
      gnt_w = bus.w_req;
      // A read aimed at the address being written this cycle waits a cycle.
      ok0 = bus.r0_req && !(bus.w_req && (bus.r0_addr == bus.w_addr));
      ok1 = bus.r1_req && !(bus.w_req && (bus.r1_addr == bus.w_addr));
      if (ok0 && ok1) begin
        gnt0 = last_rd;
        gnt1 = !last_rd;
      end else begin
        gnt0 = ok0;
        gnt1 = ok1;
      end
    end
  end

  assign rd_issue = gnt0 | gnt1;

  assign bus.r0_gnt             = gnt0;
  assign bus.r1_gnt             = gnt1;
  assign bus.w_gnt              = gnt_w;
  assign bus.ext_mem_read_en    = rd_issue;
  assign bus.ext_mem_read_addr  = gnt0 ? bus.r0_addr :
                                  (gnt1 ? bus.r1_addr : {ADDR_WIDTH{1'b0}});
  assign bus.ext_mem_write_en   = gnt_w;
  assign bus.ext_mem_write_addr = gnt_w ? bus.w_addr : {ADDR_WIDTH{1'b0}};
  assign bus.ext_mem_din        = gnt_w ? bus.w_data : {DATA_WIDTH{1'b0}};

  // Stage p0 -> p1: response tag follows the memory's one-cycle read latency.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      last_rd       <= 1'b1;
      tag_vld_p1    <= 1'b0;
      tag_client_p1 <= 1'b0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
    end else begin
      tag_vld_p1    <= rd_issue;
      tag_client_p1 <= gnt1;
      if (rd_issue) begin
        last_rd <= gnt1;
      end
      if (bus.clear_counts) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_issue) rd_cnt <= sat_inc(rd_cnt);
        if (gnt_w)    wr_cnt <= sat_inc(wr_cnt);
      end
    end
  end

  assign bus.r0_rvalid = tag_vld_p1 && !tag_client_p1;
  assign bus.r1_rvalid = tag_vld_p1 && tag_client_p1;
  assign bus.r0_rdata  = bus.ext_mem_qout;
  assign bus.r1_rdata  = bus.ext_mem_qout;
  assign bus.rd_count  = rd_cnt;
  assign bus.wr_count  = wr_cnt;

endmodule
